// File: rtl/bcd_score_counter.sv
// Packed-BCD game score counter with BCD increment, saturate/wrap overflow,
// session high-score register and leading-zero blanking mask.
module bcd_score_counter #(
    parameter int unsigned DIGITS   = 5,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [3:0]            inc,
    input  logic                  restart,
    input  logic                  game_over,
    output logic [4*DIGITS-1:0]   q,
    output logic [4*DIGITS-1:0]   best,
    output logic                  ovf,
    output logic                  new_best,
    output logic [DIGITS-1:0]     blank
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [3:0]          amt;
    logic [4*DIGITS-1:0] sum;
    logic                carry;
    logic [4:0]          dsum;

    assign amt = (inc > 4'd9) ? 4'd9 : inc;

    // Single-cycle ripple: each digit adds the incoming carry, corrects past 9.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        dsum  = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            dsum = {1'b0, q[4*d +: 4]} + {4'd0, carry};
            if (d == 0)
                dsum = dsum + {1'b0, amt};
            if (dsum > 5'd9) begin
                dsum  = dsum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*d +: 4] = dsum[3:0];
        end
    end

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (q[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q        <= '0;
            best     <= '0;
            ovf      <= 1'b0;
            new_best <= 1'b0;
        end else begin
            new_best <= 1'b0;
            if (game_over && (q > best)) begin
                best     <= q;
                new_best <= 1'b1;
            end
            // Commit above samples pre-edge q, so a simultaneous restart still clears.
            if (restart) begin
                q   <= '0;
                ovf <= 1'b0;
            end else if (en && !game_over) begin
                if (carry) begin
                    ovf <= 1'b1;
                    q   <= SATURATE ? ALL_NINES : sum;
                end else begin
                    q <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: vector table plus multi-cycle sequences,
// with a saturating and a wrapping instance driven by the same stimulus.
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  inc = 4'd0;
    logic        restart = 1'b0;
    logic        game_over = 1'b0;

    logic [19:0] sq, sbest, wq, wbest;
    logic        sovf, snb, wovf, wnb;
    logic [4:0]  sblank, wblank;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned m = 0;

    always #5 clk = ~clk;

    bcd_score_counter #(.DIGITS(5), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clr(clr), .en(en), .inc(inc), .restart(restart),
        .game_over(game_over), .q(sq), .best(sbest), .ovf(sovf),
        .new_best(snb), .blank(sblank)
    );

    bcd_score_counter #(.DIGITS(5), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clr(clr), .en(en), .inc(inc), .restart(restart),
        .game_over(game_over), .q(wq), .best(wbest), .ovf(wovf),
        .new_best(wnb), .blank(wblank)
    );

    typedef struct {
        logic        en;
        logic [3:0]  inc;
        logic        restart;
        logic        game_over;
        logic [19:0] q;
        logic [19:0] best;
        logic        ovf;
        logic        nb;
        logic [4:0]  blank;
    } vec_t;

    vec_t vec[14];

    function automatic logic [19:0] bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic [3:0] i, input logic r, input logic g);
        en = e; inc = i; restart = r; game_over = g;
    endtask

    task automatic add_to(input int unsigned target);
        int unsigned step;
        while (m < target) begin
            step = (target - m > 9) ? 9 : target - m;
            drive(1'b1, 4'(step), 1'b0, 1'b0);
            cycle();
            m += step;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vec[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 20'h00001, 20'h0, 1'b0, 1'b0, 5'b11110};
        vec[1]  = '{1'b1, 4'd9,  1'b0, 1'b0, 20'h00010, 20'h0, 1'b0, 1'b0, 5'b11100};
        vec[2]  = '{1'b1, 4'd15, 1'b0, 1'b0, 20'h00019, 20'h0, 1'b0, 1'b0, 5'b11100};
        vec[3]  = '{1'b1, 4'd0,  1'b0, 1'b0, 20'h00019, 20'h0, 1'b0, 1'b0, 5'b11100};
        vec[4]  = '{1'b1, 4'd1,  1'b0, 1'b0, 20'h00020, 20'h0, 1'b0, 1'b0, 5'b11100};
        vec[5]  = '{1'b0, 4'd5,  1'b0, 1'b0, 20'h00020, 20'h0, 1'b0, 1'b0, 5'b11100};
        vec[6]  = '{1'b1, 4'd5,  1'b0, 1'b1, 20'h00020, 20'h00020, 1'b0, 1'b1, 5'b11100};
        vec[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 20'h00020, 20'h00020, 1'b0, 1'b0, 5'b11100};
        vec[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 20'h00020, 20'h00020, 1'b0, 1'b0, 5'b11100};
        vec[9]  = '{1'b1, 4'd9,  1'b1, 1'b0, 20'h00000, 20'h00020, 1'b0, 1'b0, 5'b11110};
        vec[10] = '{1'b1, 4'd9,  1'b0, 1'b1, 20'h00000, 20'h00020, 1'b0, 1'b0, 5'b11110};
        vec[11] = '{1'b1, 4'd8,  1'b0, 1'b0, 20'h00008, 20'h00020, 1'b0, 1'b0, 5'b11110};
        vec[12] = '{1'b1, 4'd9,  1'b0, 1'b0, 20'h00017, 20'h00020, 1'b0, 1'b0, 5'b11100};
        vec[13] = '{1'b1, 4'd12, 1'b0, 1'b0, 20'h00026, 20'h00020, 1'b0, 1'b0, 5'b11100};

        #12;
        check("reset q", sq, 20'h0);
        check("reset best", sbest, 20'h0);
        check("reset ovf", {19'd0, sovf}, 20'h0);
        check("reset new_best", {19'd0, snb}, 20'h0);
        check("reset blank", {15'd0, sblank}, 20'h1e);
        @(negedge clk);
        clr = 1'b0;

        foreach (vec[k]) begin
            drive(vec[k].en, vec[k].inc, vec[k].restart, vec[k].game_over);
            cycle();
            check($sformatf("vec%0d q", k), sq, vec[k].q);
            check($sformatf("vec%0d best", k), sbest, vec[k].best);
            check($sformatf("vec%0d ovf", k), {19'd0, sovf}, {19'd0, vec[k].ovf});
            check($sformatf("vec%0d new_best", k), {19'd0, snb}, {19'd0, vec[k].nb});
            check($sformatf("vec%0d blank", k), {15'd0, sblank}, {15'd0, vec[k].blank});
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset and count by one
        clr = 1'b1;
        #2;
        clr = 1'b0;
        m = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 4'd1, 1'b0, 1'b0);
            cycle();
        end
        m = 12;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("count12 q", sq, 20'h00012);
        check("count12 blank", {15'd0, sblank}, 20'h1c);
        check("count12 ovf", {19'd0, sovf}, 20'h0);

        // Mixed increments across a two-digit carry, and clamp
        add_to(95);
        check("reach 95", sq, 20'h00095);
        drive(1'b1, 4'd7, 1'b0, 1'b0); cycle();
        check("95+7", sq, 20'h00102);
        drive(1'b1, 4'd15, 1'b0, 1'b0); cycle();
        check("102+clamp9", sq, 20'h00111);
        check("111 blank", {15'd0, sblank}, 20'h18);

        // High score commit, no-commit, and commit with restart
        drive(1'b0, 4'd0, 1'b1, 1'b0); cycle(); m = 0;
        add_to(250);
        drive(1'b0, 4'd0, 1'b0, 1'b1); cycle();
        check("hs1 best", sbest, 20'h00250);
        check("hs1 new_best", {19'd0, snb}, 20'h1);
        drive(1'b0, 4'd0, 1'b0, 1'b0); cycle();
        check("hs1 pulse end", {19'd0, snb}, 20'h0);
        drive(1'b0, 4'd0, 1'b1, 1'b0); cycle(); m = 0;
        add_to(120);
        drive(1'b0, 4'd0, 1'b0, 1'b1); cycle();
        check("hs2 best kept", sbest, 20'h00250);
        check("hs2 no pulse", {19'd0, snb}, 20'h0);
        drive(1'b0, 4'd0, 1'b1, 1'b0); cycle(); m = 0;
        add_to(300);
        drive(1'b1, 4'd4, 1'b1, 1'b1); cycle(); m = 0;
        check("go+rst best", sbest, 20'h00300);
        check("go+rst q", sq, 20'h0);
        check("go+rst pulse", {19'd0, snb}, 20'h1);

        // Overflow: saturate vs wrap
        add_to(99995);
        check("reach 99995 sat", sq, 20'h99995);
        check("reach 99995 wrap", wq, 20'h99995);
        drive(1'b1, 4'd3, 1'b0, 1'b0); cycle();
        check("99998 sat", sq, 20'h99998);
        check("99998 no ovf", {19'd0, sovf}, 20'h0);
        drive(1'b1, 4'd3, 1'b0, 1'b0); cycle();
        check("sat q", sq, 20'h99999);
        check("sat ovf", {19'd0, sovf}, 20'h1);
        check("wrap q", wq, 20'h00001);
        check("wrap ovf", {19'd0, wovf}, 20'h1);
        check("wrap blank", {15'd0, wblank}, 20'h1e);
        drive(1'b1, 4'd1, 1'b0, 1'b0); cycle();
        check("sat hold", sq, 20'h99999);
        check("sat ovf sticky", {19'd0, sovf}, 20'h1);
        check("wrap next", wq, 20'h00002);
        check("wrap ovf sticky", {19'd0, wovf}, 20'h1);
        drive(1'b1, 4'd5, 1'b1, 1'b0); cycle(); m = 0;
        check("restart q", sq, 20'h0);
        check("restart ovf", {19'd0, sovf}, 20'h0);
        check("restart wrap ovf", {19'd0, wovf}, 20'h0);

        // Asynchronous clear between edges
        drive(1'b1, 4'd1, 1'b0, 1'b0);
        cycle(); cycle();
        check("pre-clr q", sq, 20'h00002);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("async q", sq, 20'h0);
        check("async best", sbest, 20'h0);
        check("async ovf", {19'd0, sovf}, 20'h0);
        check("async new_best", {19'd0, snb}, 20'h0);
        @(negedge clk);
        clr = 1'b0;
        cycle();
        check("resume q", sq, 20'h00001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/bcd_score_counter.md
# bcd_score_counter

Parametrised N-digit packed-BCD score counter for the game score path. It generalises the fixed 5-digit count-by-one counter with a per-cycle BCD increment amount, a selectable saturate/wrap policy and a sticky overflow flag. It also adds a session high-score register with a commit strobe and a leading-zero blanking mask for the seven-segment driver. It sits between the game FSM, which issues increments, restart and game-over, and the score display mux.

## Interface

Parameters:
- DIGITS, 5: number of BCD digits; legal range 1..8.
- SATURATE, 1: 1 = hold at all-nines on overflow; 0 = wrap modulo 10^DIGITS.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- clr, input, 1: reset, asynchronous, active-high; clears all state.
- en, input, 1: add inc to the score this cycle.
- inc, input, 4: BCD amount to add, 0..9; values 10..15 are clamped to 9.
- restart, input, 1: synchronous clear of score and overflow flag; best is preserved.
- game_over, input, 1: commit the current score to best if it is strictly greater.
- q, output, 4*DIGITS: current score, packed BCD; digit 0 is q[3:0].
- best, output, 4*DIGITS: high score, packed BCD.
- ovf, output, 1: sticky flag, set when an increment would exceed 10^DIGITS-1.
- new_best, output, 1: registered one-cycle pulse, high the cycle after best was updated.
- blank, output, DIGITS: bit i = 1 when digit i of q is a leading zero. Digit 0 is never blanked.

## Operation

- Reset (clr=1, asynchronous): q=0, best=0, ovf=0, new_best=0. blank = {DIGITS-1{1}},0.
- Priority per edge, highest first: clr, then game_over/restart, then en.
- en=1, no restart/game_over: q <= q + clamp(inc).
  - Single-cycle ripple BCD add; digit-wise sum > 9 subtracts 10 and carries into the next digit.
  - Carry out of the top digit is the overflow condition.
- Overflow with SATURATE=1: q <= all digits 9; ovf <= 1.
- Overflow with SATURATE=0: q <= truncated sum (wrap); ovf <= 1.
- ovf remains 1 until restart or clr.
- en=1 with inc=0: q unchanged; no overflow possible.
- game_over=1: compare q (pre-edge value) against best as unsigned BCD. Digit-wise compare from the MSD is equivalent to binary compare of packed BCD.
  - If q > best: best <= q; new_best <= 1 next cycle.
  - If q == best: no update; new_best=0.
  - Any en in the same cycle is ignored, so the score freezes.
- restart=1: q <= 0; ovf <= 0; en in the same cycle is ignored.
- game_over and restart in the same cycle: the commit uses pre-edge q, then q clears. Both take effect on the same edge.
- blank is combinational from q. Bit i (i≥1) = 1 when digit i and all higher digits are 0.
- q never holds a non-BCD digit; no input sequence can produce a digit > 9.

## Timing

- Increment latency: 1 cycle; q reflects the addition at the edge where en was sampled.
- Back-to-back en is legal every cycle; full throughput.
- best updates 1 cycle after game_over is sampled.
- new_best is high for exactly the cycle after that edge and low otherwise. Held game_over does not re-pulse, because q == best after the first commit.
- ovf sets on the same edge as the overflowing increment.
- clr asserted mid-operation: all outputs go to reset values immediately, regardless of clk. Release is synchronous to the next edge.
- Critical path: the DIGITS-stage carry ripple, which must close at the game clock with DIGITS=8.

## Test plan

- Reset/count (DIGITS=5): pulse clr, then en=1, inc=1 for 12 cycles -> q=0x00012, blank=5'b11100, ovf=0.
- Mixed increments: from 0x00095 apply inc=7 -> q=0x00102; apply inc=15 -> clamped to 9, q=0x00111.
- Saturate (SATURATE=1): q=0x99995, inc=9 -> q=0x99999, ovf=1; a further inc=1 keeps q=0x99999; restart -> q=0, ovf=0.
- Wrap (SATURATE=0): q=0x99998, inc=3 -> q=0x00001, ovf=1, blank=5'b11110.
- High score: score 0x00250 then game_over -> best=0x00250, new_best pulses 1 cycle. Restart and score 0x00120 then game_over -> best unchanged, no pulse. game_over+restart together at q=0x00300 -> best=0x00300, q=0.
- Async reset mid-run: assert clr between edges while en=1 -> q, best, ovf and new_best go to 0 before the next edge. Counting resumes on the first edge after release.
